i2c_bus_timeout_mon: RTL

- Downstream consumer of the 1 µs tick produced by the microsecond timer.
- Owns that timer's `cnt_en`, so it decides when the tick prescaler runs and when it restarts.
- Tracks I2C/SMBus bus state: START/STOP detection, bus-idle qualification, and an SCL-low watchdog.
- Raises a sticky timeout flag plus a one-cycle event when SCL is held low too long. The CPLD I2C slave logic uses these to abort and release the bus.

---
 rtl/i2c_mon_pkg.sv | 21 ++
 rtl/i2c_start_stop_det.sv | 30 +++
 rtl/i2c_bus_timeout_mon.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_mon_pkg.sv
// Shared encodings and constants for the I2C bus timeout monitor and its us timer.
package i2c_mon_pkg;

    localparam logic [2:0] ST_DISABLED = 3'd0;
    localparam logic [2:0] ST_IDLE_CHK = 3'd1;
    localparam logic [2:0] ST_IDLE     = 3'd2;
    localparam logic [2:0] ST_BUSY     = 3'd3;
    localparam logic [2:0] ST_SCL_LOW  = 3'd4;
    localparam logic [2:0] ST_TMO      = 3'd5;

    localparam int SCL_LOW_MAX_US_DEF = 25000;
    localparam int IDLE_US_DEF        = 50;

    // Terminal count of the us prescaler: one tick every COUNT_1US+1 sys_clk cycles.
    localparam int COUNT_1US = 50;

    function automatic logic is_timed_state(input logic [2:0] st);
        return (st == ST_IDLE_CHK) || (st == ST_SCL_LOW);
    endfunction

endpackage

// File: rtl/i2c_start_stop_det.sv
// Registers the synchronised bus lines and flags START, STOP and SCL falling edges.
module i2c_start_stop_det (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic start,
    output logic stop,
    output logic scl_fall
);

    logic scl_d_r;
    logic sda_d_r;

    // Previous-cycle bus levels; reset to the released (high) level so reset never fakes an edge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            scl_d_r <= 1'b1;
            sda_d_r <= 1'b1;
        end else begin
            scl_d_r <= scl_in;
            sda_d_r <= sda_in;
        end
    end

    assign start    = scl_d_r & scl_in & sda_d_r & ~sda_in;
    assign stop     = scl_d_r & scl_in & ~sda_d_r & sda_in;
    assign scl_fall = scl_d_r & ~scl_in;

endmodule

// File: rtl/i2c_bus_timeout_mon.sv
// I2C/SMBus bus state tracker with idle qualification and SCL-low watchdog driven by a us tick.
module i2c_bus_timeout_mon
    import i2c_mon_pkg::*;
#(
    parameter int SCL_LOW_MAX_US = SCL_LOW_MAX_US_DEF,
    parameter int IDLE_US        = IDLE_US_DEF,
    parameter int CNT_W          = 16
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             enable,
    input  logic             scl_in,
    input  logic             sda_in,
    input  logic             us_tick,
    input  logic             clr,
    output logic             tmr_en,
    output logic             bus_busy,
    output logic             bus_idle,
    output logic             scl_timeout,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] cnt_us
);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             start_s;
    logic             stop_s;
    logic             scl_fall_s;
    logic             tmr_en_r;
    logic             bus_busy_r;
    logic             bus_idle_r;
    logic             scl_timeout_r;
    logic             timeout_pulse_r;
    logic             tmr_en_nxt_s;
    logic             bus_busy_nxt_s;
    logic             bus_idle_nxt_s;
    logic             scl_timeout_nxt_s;
    logic             timeout_pulse_nxt_s;

    i2c_start_stop_det u_det (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .start    (start_s),
        .stop     (stop_s),
        .scl_fall (scl_fall_s)
    );

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= ST_DISABLED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and next count; the counter saturates and restarts on every state entry
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        cnt_inc_s   = (&cnt_r) ? cnt_r : cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (!enable) begin
            state_nxt_s = ST_DISABLED;
        end else begin
            case (state_r)
                ST_DISABLED: state_nxt_s = ST_IDLE_CHK;
                ST_IDLE_CHK: begin
                    if (!scl_in) begin
                        state_nxt_s = ST_SCL_LOW;
                    end else if (start_s) begin
                        state_nxt_s = ST_BUSY;
                    end else if (!sda_in) begin
                        cnt_nxt_s = '0;
                    end else if (us_tick) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_W'(IDLE_US)) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            state_nxt_s = ST_IDLE_CHK;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_IDLE: begin
                    if (start_s) begin
                        state_nxt_s = ST_BUSY;
                    end else if (scl_fall_s) begin
                        state_nxt_s = ST_SCL_LOW;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (stop_s) begin
                        state_nxt_s = ST_IDLE_CHK;
                    end else if (!scl_in) begin
                        state_nxt_s = ST_SCL_LOW;
                    end else begin
                        state_nxt_s = ST_BUSY;
                    end
                end
                ST_SCL_LOW: begin
                    // A release in the same cycle as the final tick beats the timeout
                    if (scl_in) begin
                        state_nxt_s = ST_BUSY;
                    end else if (us_tick) begin
                        cnt_nxt_s = cnt_inc_s;
                        if (cnt_inc_s == CNT_W'(SCL_LOW_MAX_US)) begin
                            state_nxt_s = ST_TMO;
                        end else begin
                            state_nxt_s = ST_SCL_LOW;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_TMO: begin
                    if (scl_in) begin
                        state_nxt_s = ST_IDLE_CHK;
                    end else begin
                        state_nxt_s = ST_TMO;
                    end
                end
                default: state_nxt_s = ST_DISABLED;
            endcase
        end
        if ((state_nxt_s != state_r) || (state_nxt_s == ST_DISABLED)) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_nxt_s;
        end
    end

    // Next output values; tmr_en stays low on the entry cycle so the prescaler restarts
    always_comb begin
        tmr_en_nxt_s        = is_timed_state(state_nxt_s) && (state_nxt_s == state_r);
        bus_busy_nxt_s      = (state_nxt_s == ST_BUSY) || (state_nxt_s == ST_SCL_LOW) ||
                              (state_nxt_s == ST_TMO);
        bus_idle_nxt_s      = (state_nxt_s == ST_IDLE);
        timeout_pulse_nxt_s = (state_r == ST_SCL_LOW) && (state_nxt_s == ST_TMO);
        if (timeout_pulse_nxt_s) begin
            scl_timeout_nxt_s = 1'b1;
        end else if (clr) begin
            scl_timeout_nxt_s = 1'b0;
        end else begin
            scl_timeout_nxt_s = scl_timeout_r;
        end
    end

    // Counter and output registers
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_r           <= '0;
            tmr_en_r        <= 1'b0;
            bus_busy_r      <= 1'b0;
            bus_idle_r      <= 1'b0;
            scl_timeout_r   <= 1'b0;
            timeout_pulse_r <= 1'b0;
        end else begin
            cnt_r           <= cnt_nxt_s;
            tmr_en_r        <= tmr_en_nxt_s;
            bus_busy_r      <= bus_busy_nxt_s;
            bus_idle_r      <= bus_idle_nxt_s;
            scl_timeout_r   <= scl_timeout_nxt_s;
            timeout_pulse_r <= timeout_pulse_nxt_s;
        end
    end

    assign tmr_en        = tmr_en_r;
    assign bus_busy      = bus_busy_r;
    assign bus_idle      = bus_idle_r;
    assign scl_timeout   = scl_timeout_r;
    assign timeout_pulse = timeout_pulse_r;
    assign cnt_us        = cnt_r;

endmodule
